// File: rtl/intra16x16_mode_ctrl.sv
// Sequencer and V/H/DC mode-decision controller for the 16x16 luma intra predictor.
// Optional abort input enabled by defining INTRA16_ABORT_EN.
module intra16x16_mode_ctrl #(
  parameter int PIX_W = 8,
  parameter int ROWS  = 16,
  parameter int SAD_W = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
`ifdef INTRA16_ABORT_EN
  input  logic                      abort,
`endif
  input  logic                      top_avail,
  input  logic                      left_avail,
  output logic                      pred_en,
  output logic [$clog2(ROWS)-1:0]   row_idx,
  input  logic [ROWS*PIX_W-1:0]     vpred_row,
  input  logic [ROWS*PIX_W-1:0]     hpred_row,
  input  logic [ROWS*PIX_W-1:0]     dcpred_row,
  input  logic [ROWS*PIX_W-1:0]     orig_row,
  input  logic                      orig_valid,
  output logic                      orig_ready,
  output logic                      busy,
  output logic                      done,
  output logic [1:0]                best_mode,
  output logic [SAD_W-1:0]          best_sad
);

  localparam int RIDX_W = $clog2(ROWS);
  localparam int ROW_W  = PIX_W + $clog2(ROWS);
  localparam logic [RIDX_W-1:0] LAST_ROW = RIDX_W'(ROWS - 1);

  localparam logic [1:0] MODE_V  = 2'd0;
  localparam logic [1:0] MODE_H  = 2'd1;
  localparam logic [1:0] MODE_DC = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRE,
    S_WAIT,
    S_SAD,
    S_DECIDE,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [RIDX_W-1:0] row_idx_q, row_idx_d;
  logic [SAD_W-1:0]  sad_v_q, sad_v_d;
  logic [SAD_W-1:0]  sad_h_q, sad_h_d;
  logic [SAD_W-1:0]  sad_dc_q, sad_dc_d;
  logic              top_q, top_d;
  logic              left_q, left_d;
  logic [1:0]        best_mode_q, best_mode_d;
  logic [SAD_W-1:0]  best_sad_q, best_sad_d;

  logic              abort_w;
  logic              accept;
  logic              beat;
  logic              decide_en;
  logic [ROW_W-1:0]  row_v, row_h, row_dc;
  logic [1:0]        dec_mode;
  logic [SAD_W-1:0]  dec_sad;

`ifdef INTRA16_ABORT_EN
  assign abort_w = abort && (state_q != S_IDLE);
`else
  assign abort_w = 1'b0;
`endif

  function automatic logic [PIX_W-1:0] absdiff(input logic [PIX_W-1:0] a,
                                               input logic [PIX_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pred_en    = 1'b0;
    orig_ready = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_d = S_FIRE;
      end
      S_FIRE: begin
        pred_en = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: state_d = S_SAD;
      S_SAD: begin
        orig_ready = 1'b1;
        if (orig_valid && (row_idx_q == LAST_ROW)) state_d = S_DECIDE;
      end
      S_DECIDE: state_d = S_DONE;
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
    // Abort overrides the whole transition table and suppresses the done pulse.
    if (abort_w) begin
      state_d = S_IDLE;
      done    = 1'b0;
    end
  end

  assign accept    = (state_q == S_IDLE) && start;
  assign beat      = (state_q == S_SAD) && orig_valid && !abort_w;
  assign decide_en = (state_q == S_DECIDE) && !abort_w;

  // ---------------------------------------------------------------------------
  // Per-row SAD for the three candidate predictions
  // ---------------------------------------------------------------------------
  always_comb begin
    row_v  = '0;
    row_h  = '0;
    row_dc = '0;
    for (int unsigned c = 0; c < ROWS; c++) begin
      row_v  = row_v  + ROW_W'(absdiff(vpred_row[c*PIX_W +: PIX_W],
                                       orig_row[c*PIX_W +: PIX_W]));
      row_h  = row_h  + ROW_W'(absdiff(hpred_row[c*PIX_W +: PIX_W],
                                       orig_row[c*PIX_W +: PIX_W]));
      row_dc = row_dc + ROW_W'(absdiff(dcpred_row[c*PIX_W +: PIX_W],
                                       orig_row[c*PIX_W +: PIX_W]));
    end
  end

  // Evaluated from DC upward with <= so that ties fall to the lower mode number.
  always_comb begin
    dec_mode = MODE_DC;
    dec_sad  = sad_dc_q;
    if (left_q && (sad_h_q <= dec_sad)) begin
      dec_mode = MODE_H;
      dec_sad  = sad_h_q;
    end
    if (top_q && (sad_v_q <= dec_sad)) begin
      dec_mode = MODE_V;
      dec_sad  = sad_v_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_comb begin
    row_idx_d   = row_idx_q;
    sad_v_d     = sad_v_q;
    sad_h_d     = sad_h_q;
    sad_dc_d    = sad_dc_q;
    top_d       = top_q;
    left_d      = left_q;
    best_mode_d = best_mode_q;
    best_sad_d  = best_sad_q;
    if (accept) begin
      row_idx_d = '0;
      sad_v_d   = '0;
      sad_h_d   = '0;
      sad_dc_d  = '0;
      top_d     = top_avail;
      left_d    = left_avail;
    end
    if (beat) begin
      sad_v_d   = sad_v_q  + SAD_W'(row_v);
      sad_h_d   = sad_h_q  + SAD_W'(row_h);
      sad_dc_d  = sad_dc_q + SAD_W'(row_dc);
      row_idx_d = (row_idx_q == LAST_ROW) ? '0 : row_idx_q + 1'b1;
    end
    if (decide_en) begin
      best_mode_d = dec_mode;
      best_sad_d  = dec_sad;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_idx_q   <= '0;
      sad_v_q     <= '0;
      sad_h_q     <= '0;
      sad_dc_q    <= '0;
      top_q       <= 1'b0;
      left_q      <= 1'b0;
      best_mode_q <= MODE_DC;
      best_sad_q  <= '0;
    end else begin
      row_idx_q   <= row_idx_d;
      sad_v_q     <= sad_v_d;
      sad_h_q     <= sad_h_d;
      sad_dc_q    <= sad_dc_d;
      top_q       <= top_d;
      left_q      <= left_d;
      best_mode_q <= best_mode_d;
      best_sad_q  <= best_sad_d;
    end
  end

  assign row_idx   = row_idx_q;
  assign best_mode = best_mode_q;
  assign best_sad  = best_sad_q;

endmodule

// File: tb/tb_intra16x16_mode_ctrl.sv
// Randomised self-checking bench for intra16x16_mode_ctrl against a per-pixel SAD model.
// Abort scenario is exercised when INTRA16_ABORT_EN is defined.
module tb_intra16x16_mode_ctrl;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         top_avail = 1'b0;
  logic         left_avail = 1'b0;
  logic         pred_en;
  logic [3:0]   row_idx;
  logic [127:0] vpred_row, hpred_row, dcpred_row;
  logic [127:0] orig_row = '0;
  logic         orig_valid = 1'b0;
  logic         orig_ready, busy, done;
  logic [1:0]   best_mode;
  logic [15:0]  best_sad;

  logic [127:0] vrows[16];
  logic [127:0] hrows[16];
  logic [127:0] drows[16];
  logic [127:0] orows[16];

  int n_checks = 0;
  int n_fail   = 0;
  int prev_mode = 2;
  int prev_sad  = 0;
  int fin_last;

  always #5 clk = ~clk;

  assign vpred_row  = vrows[row_idx];
  assign hpred_row  = hrows[row_idx];
  assign dcpred_row = drows[row_idx];

  intra16x16_mode_ctrl #(.PIX_W(8), .ROWS(16), .SAD_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
`ifdef INTRA16_ABORT_EN
    .abort      (abort),
`endif
    .top_avail  (top_avail),
    .left_avail (left_avail),
    .pred_en    (pred_en),
    .row_idx    (row_idx),
    .vpred_row  (vpred_row),
    .hpred_row  (hpred_row),
    .dcpred_row (dcpred_row),
    .orig_row   (orig_row),
    .orig_valid (orig_valid),
    .orig_ready (orig_ready),
    .busy       (busy),
    .done       (done),
    .best_mode  (best_mode),
    .best_sad   (best_sad)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill_const(input int v, input int h, input int dc, input int o);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        vrows[r][c*8 +: 8] = 8'(v);
        hrows[r][c*8 +: 8] = 8'(h);
        drows[r][c*8 +: 8] = 8'(dc);
        orows[r][c*8 +: 8] = 8'(o);
      end
  endtask

  task automatic fill_rand();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        vrows[r][c*8 +: 8] = 8'($urandom_range(0, 255));
        hrows[r][c*8 +: 8] = 8'($urandom_range(0, 255));
        drows[r][c*8 +: 8] = 8'($urandom_range(0, 255));
        orows[r][c*8 +: 8] = 8'($urandom_range(0, 255));
      end
  endtask

  // Whole-block SAD per mode, then the cheapest allowed mode (first minimum wins).
  function automatic void model(input logic t, input logic l, output int m, output int s);
    int sad[3];
    bit allow[3];
    sad = '{0, 0, 0};
    allow = '{t, l, 1'b1};
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        int o, p;
        o = int'(orows[r][c*8 +: 8]);
        p = int'(vrows[r][c*8 +: 8]); sad[0] += (p > o) ? p - o : o - p;
        p = int'(hrows[r][c*8 +: 8]); sad[1] += (p > o) ? p - o : o - p;
        p = int'(drows[r][c*8 +: 8]); sad[2] += (p > o) ? p - o : o - p;
      end
    m = -1;
    s = 0;
    for (int k = 0; k < 3; k++)
      if (allow[k] && (m < 0 || sad[k] < s)) begin
        m = k;
        s = sad[k];
      end
  endfunction

  task automatic idle_watch(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0)
        check("no_done_after_kill", {30'd0, done, busy}, 0);
      orig_valid = 1'($urandom_range(0, 1));
    end
    check("held_mode", best_mode, prev_mode);
    check("held_sad", best_sad, prev_sad);
  endtask

  // vmode: 0 valid always, 1 valid on alternate cycles, 2 random
  // kill:  0 none, 1 reset at row 7, 2 abort at row 5
  task automatic run_mb(input logic t, input logic l, input int vmode, input int kill);
    int beats, fin, em, es;
    bit hit;
    logic [3:0] ectl;
    model(t, l, em, es);
    @(negedge clk);
    top_avail  = t;
    left_avail = l;
    start      = 1'b1;
    orig_valid = 1'($urandom_range(0, 1));
    orig_row   = orows[0];
    beats = 0;
    fin   = -1;
    hit   = 1'b0;
    fin_last = -1;
    for (int d = 1; d <= 120 && !hit; d++) begin
      bit in_sad;
      @(negedge clk);
      in_sad = (d >= 3) && (beats < 16);
      ectl = {d == 1, in_sad, (fin < 0) || (d <= fin), d == fin};
      check("ctl{pred_en,orig_ready,busy,done}", {28'd0, pred_en, orig_ready, busy, done},
            {28'd0, ectl});
      if (in_sad) check("row_idx", row_idx, beats);
      if (d == fin) begin
        check("best_mode", best_mode, em);
        check("best_sad", best_sad, es);
        check("row_idx_wrap", row_idx, 0);
        prev_mode = em;
        prev_sad  = es;
        fin_last  = fin;
      end
      if (fin > 0 && d == fin + 1) hit = 1'b1;

      if (kill == 1 && in_sad && beats == 7) begin
        start = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_ctl", {28'd0, pred_en, orig_ready, busy, done}, 0);
        check("rst_row", row_idx, 0);
        prev_mode = 2;
        prev_sad  = 0;
        @(negedge clk);
        reset = 1'b0;
        idle_watch(25);
        return;
      end
      if (kill == 2 && in_sad && beats == 5) begin
        start = 1'b0;
        abort = 1'b1;
        orig_valid = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_ctl", {28'd0, pred_en, orig_ready, busy, done}, 0);
        idle_watch(25);
        return;
      end

      start      = ((fin < 0) || (d <= fin)) ? ($urandom_range(0, 3) == 0) : 1'b0;
      top_avail  = 1'($urandom_range(0, 1));
      left_avail = 1'($urandom_range(0, 1));
      case (vmode)
        0:       orig_valid = 1'b1;
        1:       orig_valid = (d % 2 == 0);
        default: orig_valid = ($urandom_range(0, 3) != 0);
      endcase
      orig_row = orows[beats[3:0]];
      if (in_sad && orig_valid) begin
        beats++;
        if (beats == 16) fin = d + 2;
      end
    end
    if (!hit) check("timeout", 0, 1);
    start = 1'b0;
  endtask

  initial begin
    fill_const(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("reset_ctl", {28'd0, pred_en, orig_ready, busy, done}, 0);
    check("reset_row", row_idx, 0);
    check("reset_mode", best_mode, 2);
    check("reset_sad", best_sad, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Case 1: top=100, left=50, DC=75, orig=100
    fill_const(100, 50, 75, 100);
    run_mb(1'b1, 1'b1, 0, 0);
    check("c1_mode", best_mode, 0);
    check("c1_sad", best_sad, 0);
    check("c1_latency", fin_last, 20);

    // Case 2: V excluded
    run_mb(1'b0, 1'b1, 0, 0);
    check("c2_mode", best_mode, 2);
    check("c2_sad", best_sad, 6400);

    // Case 3: all equal -> tie to V
    fill_const(80, 80, 80, 80);
    run_mb(1'b1, 1'b1, 0, 0);
    check("c3_mode", best_mode, 0);
    check("c3_sad", best_sad, 0);

    // Case 4: alternate stalls
    fill_const(100, 50, 75, 100);
    run_mb(1'b1, 1'b1, 1, 0);
    check("c4_mode", best_mode, 0);
    check("c4_latency", fin_last, 36);

    for (int i = 0; i < 30; i++) begin
      fill_rand();
      run_mb(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), i % 3, 0);
    end

    // Case 5: reset at row 7, then case 2 data
    fill_const(100, 50, 75, 100);
    run_mb(1'b1, 1'b1, 0, 1);
    run_mb(1'b0, 1'b1, 0, 0);
    check("c5_mode", best_mode, 2);
    check("c5_sad", best_sad, 6400);

`ifdef INTRA16_ABORT_EN
    // Case 6: abort at row 5, then case 1 data
    run_mb(1'b1, 1'b1, 2, 2);
    run_mb(1'b1, 1'b1, 0, 0);
    check("c6_mode", best_mode, 0);
    check("c6_sad", best_sad, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
